// File: rtl/des_key_sched_seq.sv
// Sequential DES key scheduler: one 48-bit subkey per valid/ready handshake,
// forward (K1..K16) or reverse (K16..K1) order, without a stored key table.
module des_key_sched_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  output logic        busy,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [4:0]  round,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // DES bit b lives at index (N - b) of an N-bit vector, so bit 1 is the MSB.
  function automatic logic [55:0] pc1_perm(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 use a single-bit shift; all others shift by two.
  function automatic logic shift_two(input logic [4:0] r);
    return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state;
  logic [27:0] c_reg, d_reg;
  logic        mode;
  logic [3:0]  count;

  logic [55:0] cd_key;
  logic [27:0] c_load, d_load, c_next, d_next;
  logic        two;

  // Load values come straight from the key; C16/D16 equal C0/D0 so decrypt needs no rotation.
  always_comb begin
    cd_key = pc1_perm(key);
    c_load = decrypt ? cd_key[55:28] : rotl(cd_key[55:28], 1'b0);
    d_load = decrypt ? cd_key[27:0]  : rotl(cd_key[27:0], 1'b0);
    two    = mode ? shift_two(round) : shift_two(round + 5'd1);
    c_next = mode ? rotr(c_reg, two) : rotl(c_reg, two);
    d_next = mode ? rotr(d_reg, two) : rotl(d_reg, two);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      c_reg        <= '0;
      d_reg        <= '0;
      mode         <= 1'b0;
      count        <= '0;
      busy         <= 1'b0;
      subkey       <= '0;
      subkey_valid <= 1'b0;
      round        <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_RUN;
            c_reg        <= c_load;
            d_reg        <= d_load;
            mode         <= decrypt;
            count        <= 4'd15;
            subkey       <= pc2_perm({c_load, d_load});
            round        <= decrypt ? 5'd16 : 5'd1;
            busy         <= 1'b1;
            subkey_valid <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (subkey_valid && subkey_ready) begin
            if (count == 4'd0) begin
              state        <= S_DONE;
              busy         <= 1'b0;
              subkey_valid <= 1'b0;
              done         <= 1'b1;
            end else begin
              count  <= count - 4'd1;
              c_reg  <= c_next;
              d_reg  <= d_next;
              subkey <= pc2_perm({c_next, d_next});
              round  <= mode ? round - 5'd1 : round + 5'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Directed + randomized bench for des_key_sched_seq against a table-driven DES key schedule model.
module tb_des_key_sched_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, decrypt, subkey_ready;
  logic [63:0] key;
  logic        busy, subkey_valid, done;
  logic [47:0] subkey;
  logic [4:0]  round;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] KEY_REF = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_REF  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_REF = 48'hCB3D8B0E17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  always #5 clk = ~clk;

  des_key_sched_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .busy         (busy),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .done         (done)
  );

  // C0||D0 with DES bit b at index 56-b.
  function automatic logic [55:0] model_cd0(input logic [63:0] k);
    logic [55:0] v;
    v = '0;
    for (int i = 1; i <= 56; i++) v[6'(56 - i)] = k[6'(64 - PC1_T[i-1])];
    return v;
  endfunction

  // Subkey n from the cumulative left shift applied to C0 and D0.
  function automatic logic [47:0] model_subkey(input logic [63:0] k, input int n);
    logic [55:0] v, cn;
    logic [47:0] o;
    int s, src;
    v = model_cd0(k);
    cn = '0;
    o = '0;
    s = 0;
    for (int j = 1; j <= n; j++) s += SHIFTS[j-1];
    for (int j = 1; j <= 28; j++) begin
      src = ((j - 1 + s) % 28) + 1;
      cn[6'(56 - j)] = v[6'(56 - src)];
      cn[6'(28 - j)] = v[6'(28 - src)];
    end
    for (int i = 1; i <= 48; i++) o[6'(48 - i)] = cn[6'(56 - PC2_T[i-1])];
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the first cycle after acceptance.
  task automatic applyStimulus(input logic [63:0] k, input logic dec);
    start   = 1'b1;
    key     = k;
    decrypt = dec;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follow one 16-subkey sequence; rmode 0 = ready held high, 1 = random ready with a round-8 stall.
  task automatic run_seq(input logic [63:0] k, input logic dec, input int rmode,
                         input logic intrude, input logic [63:0] ikey);
    logic [47:0] exp_keys [16];
    int   idx, cycles, stall, er;
    logic rdy, intr_sent;
    for (int n = 1; n <= 16; n++) exp_keys[n-1] = model_subkey(k, n);
    idx = 0; cycles = 0; stall = 0; intr_sent = 1'b0;
    checkOutput("latency_valid", 64'(subkey_valid), 64'd1);
    while (idx < 16 && cycles < 300) begin
      start = 1'b0;
      if (subkey_valid) begin
        er = dec ? 16 - idx : idx + 1;
        checkOutput("round", 64'(round), 64'(er));
        checkOutput("subkey", 64'(subkey), 64'(exp_keys[er-1]));
        checkOutput("busy_run", 64'(busy), 64'd1);
        if (!dec && er == 16) checkOutput("cd_wrap", 64'({dut.c_reg, dut.d_reg}), 64'(model_cd0(k)));
        if (rmode == 0) rdy = 1'b1;
        else if (er == 8 && stall < 5) begin rdy = 1'b0; stall++; end
        else rdy = 1'($urandom_range(0, 1));
        subkey_ready = rdy;
        if (rdy) idx++;
      end else begin
        checkOutput("valid_gap", 64'(subkey_valid), 64'd1);
        subkey_ready = 1'b1;
      end
      if (intrude && idx == 3 && !intr_sent) begin
        start = 1'b1; key = ikey; decrypt = ~dec; intr_sent = 1'b1;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checkOutput("handshakes", 64'(idx), 64'd16);
    checkOutput("done_pulse", 64'(done), 64'd1);
    checkOutput("done_valid", 64'(subkey_valid), 64'd0);
    checkOutput("done_busy", 64'(busy), 64'd0);
    checkOutput("done_round", 64'(round), dec ? 64'd1 : 64'd16);
    checkOutput("done_subkey", 64'(subkey), 64'(exp_keys[dec ? 0 : 15]));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    checkOutput("done_width", 64'(done), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rk, rk2;
    logic        rdec, saw_done;
    int          n;
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key = '0; subkey_ready = 1'b0;
    #12;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_valid", 64'(subkey_valid), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_subkey", 64'(subkey), 64'd0);
    checkOutput("rst_round", 64'(round), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] forward reference key");
    applyStimulus(KEY_REF, 1'b0);
    checkOutput("fwd_K1_vector", 64'(subkey), 64'(K1_REF));
    run_seq(KEY_REF, 1'b0, 0, 1'b0, '0);
    checkOutput("fwd_K16_vector", 64'(subkey), 64'(K16_REF));
    idle_cycle();

    $display("[TB] decrypt reference key");
    applyStimulus(KEY_REF, 1'b1);
    checkOutput("dec_K16_vector", 64'(subkey), 64'(K16_REF));
    run_seq(KEY_REF, 1'b1, 0, 1'b0, '0);
    checkOutput("dec_K1_vector", 64'(subkey), 64'(K1_REF));
    idle_cycle();

    $display("[TB] backpressure then back-to-back start in done cycle");
    rk  = {$urandom, $urandom};
    rk2 = {$urandom, $urandom};
    applyStimulus(rk, 1'b0);
    run_seq(rk, 1'b0, 1, 1'b0, '0);
    applyStimulus(rk2, 1'b1);
    run_seq(rk2, 1'b1, 1, 1'b0, '0);
    idle_cycle();

    $display("[TB] start while busy is ignored");
    applyStimulus(KEY_REF, 1'b0);
    run_seq(KEY_REF, 1'b0, 0, 1'b1, 64'hFEDCBA9876543210);
    idle_cycle();

    $display("[TB] parity bits flipped");
    applyStimulus(KEY_REF ^ 64'h0101010101010101, 1'b0);
    run_seq(KEY_REF, 1'b0, 1, 1'b0, '0);
    idle_cycle();

    $display("[TB] random keys");
    for (int t = 0; t < 3; t++) begin
      rk   = {$urandom, $urandom};
      rdec = 1'($urandom_range(0, 1));
      applyStimulus(rk, rdec);
      run_seq(rk, rdec, 1, 1'b0, '0);
      idle_cycle();
    end

    $display("[TB] asynchronous reset mid-run");
    subkey_ready = 1'b1;
    applyStimulus(KEY_REF, 1'b0);
    n = 0;
    while (round != 5'd5 && n < 40) begin @(negedge clk); n++; end
    checkOutput("reach_round5", 64'(round), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(subkey_valid), 64'd0);
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_subkey", 64'(subkey), 64'd0);
    checkOutput("arst_round", 64'(round), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || subkey_valid) saw_done = 1'b1;
    end
    checkOutput("no_done_after_abort", 64'(saw_done), 64'd0);
    applyStimulus(KEY_REF, 1'b0);
    checkOutput("fresh_K1_vector", 64'(subkey), 64'(K1_REF));
    run_seq(KEY_REF, 1'b0, 0, 1'b0, '0);
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
